// File: rtl/mcp_fetch_seq.sv
// mcp_fetch_seq: four-phase MicROM fetch sequencer with bank decode and phase strobes
module mcp_fetch_seq #(
  parameter int NROM = 4,
  parameter logic [NROM-1:0] BANK_MASK = {NROM{1'b1}},
  parameter int PH_CLKS = 1
) (
  input  logic             pin_clk,
  input  logic             pin_rst_n,
  input  logic             req,
  input  logic [10:0]      addr,
  output logic             ack,
  input  logic             stall,
  output logic             pin_c1,
  output logic             pin_c2,
  output logic             pin_c3,
  output logic             pin_c4,
  output logic [10:0]      rom_addr,
  output logic [NROM-1:0]  rom_cs,
  input  logic [21:0]      rom_data,
  output logic [21:0]      mi,
  output logic             mi_vld,
  output logic             mi_err
);
  localparam int LB = $clog2(NROM);
  localparam int BW = (LB > 0) ? LB : 1;
  localparam logic [3:0] PMAX = 4'(PH_CLKS - 1);
  typedef enum logic [2:0] {IDLE, PH2, PH3, PH4, PH1} state_t;
  state_t state_q, state_d;
  logic [3:0] pcnt_q, pcnt_d;
  logic [10:0] rom_addr_q, rom_addr_d;
  logic [BW-1:0] bank_q, bank_d;
  logic [21:0] hold_q, hold_d, mi_q, mi_d;
  logic mi_vld_q, mi_vld_d, mi_err_q, mi_err_d;
  logic last, pop;
  always_comb begin
    last = pcnt_q == PMAX;
    pop = BANK_MASK[bank_q];
    ack = req & (state_q == IDLE | (state_q == PH1 & last));
    rom_addr_d = ack ? addr : rom_addr_q;
    // top address bits select the bank; a single bank decodes to 0
    bank_d = ack ? BW'(addr >> (11 - LB)) : bank_q;
    hold_d = (state_q == PH3 & last) ? (pop ? rom_data : '0) : hold_q;
    mi_vld_d = state_q == PH4 & last & ~stall;
    mi_err_d = mi_vld_d & ~pop;
    mi_d = mi_vld_d ? hold_q : mi_q;
    state_d = state_q;
    pcnt_d = last ? '0 : pcnt_q + 4'd1;
    case (state_q)
      IDLE: begin
        state_d = ack ? PH2 : IDLE;
        pcnt_d = '0;
      end
      PH2: state_d = last ? PH3 : PH2;
      PH3: state_d = last ? PH4 : PH3;
      PH4: begin
        state_d = mi_vld_d ? PH1 : PH4;
        pcnt_d = last ? (stall ? pcnt_q : '0) : pcnt_q + 4'd1;
      end
      PH1: state_d = last ? (ack ? PH2 : IDLE) : PH1;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge pin_clk or negedge pin_rst_n) begin
    if (!pin_rst_n) begin
      state_q <= IDLE;
      pcnt_q <= '0;
      rom_addr_q <= '0;
      bank_q <= '0;
      hold_q <= '0;
      mi_q <= '0;
      mi_vld_q <= 1'b0;
      mi_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pcnt_q <= pcnt_d;
      rom_addr_q <= rom_addr_d;
      bank_q <= bank_d;
      hold_q <= hold_d;
      mi_q <= mi_d;
      mi_vld_q <= mi_vld_d;
      mi_err_q <= mi_err_d;
    end
  end
  assign pin_c1 = state_q == PH1;
  assign pin_c2 = state_q == PH2;
  assign pin_c3 = state_q == PH3;
  assign pin_c4 = state_q == PH4;
  assign rom_cs = ((state_q == PH2 | state_q == PH3) & pop) ? NROM'(1) << bank_q : '0;
  assign rom_addr = rom_addr_q;
  assign mi = mi_q;
  assign mi_vld = mi_vld_q;
  assign mi_err = mi_err_q;
endmodule

// File: tb/tb_mcp_fetch_seq.sv
// tb_mcp_fetch_seq: scoreboard bench over three configurations (full mask, bank 3 missing, 3-clock phases)
module tb_mcp_fetch_seq;
  typedef struct {
    int u;
    logic [21:0] mi;
    logic err;
    int t;
  } exp_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [2:0] req = '0, stall = '0, ack, c1, c2, c3, c4, vld, err;
  logic [10:0] addr [3];
  logic [10:0] rom_addr [3];
  logic [3:0] rom_cs [3];
  logic [21:0] rom_data [3];
  logic [21:0] mi [3];
  logic [21:0] mem [2048];
  exp_t sb [$];
  int cyc = 0;
  int n_cmp = 0, n_err = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  mcp_fetch_seq #(.NROM(4), .BANK_MASK(4'hF), .PH_CLKS(1)) u0 (
    .pin_clk(clk), .pin_rst_n(rst_n), .req(req[0]), .addr(addr[0]), .ack(ack[0]), .stall(stall[0]),
    .pin_c1(c1[0]), .pin_c2(c2[0]), .pin_c3(c3[0]), .pin_c4(c4[0]), .rom_addr(rom_addr[0]),
    .rom_cs(rom_cs[0]), .rom_data(rom_data[0]), .mi(mi[0]), .mi_vld(vld[0]), .mi_err(err[0]));
  mcp_fetch_seq #(.NROM(4), .BANK_MASK(4'h7), .PH_CLKS(1)) u1 (
    .pin_clk(clk), .pin_rst_n(rst_n), .req(req[1]), .addr(addr[1]), .ack(ack[1]), .stall(stall[1]),
    .pin_c1(c1[1]), .pin_c2(c2[1]), .pin_c3(c3[1]), .pin_c4(c4[1]), .rom_addr(rom_addr[1]),
    .rom_cs(rom_cs[1]), .rom_data(rom_data[1]), .mi(mi[1]), .mi_vld(vld[1]), .mi_err(err[1]));
  mcp_fetch_seq #(.NROM(4), .BANK_MASK(4'hF), .PH_CLKS(3)) u2 (
    .pin_clk(clk), .pin_rst_n(rst_n), .req(req[2]), .addr(addr[2]), .ack(ack[2]), .stall(stall[2]),
    .pin_c1(c1[2]), .pin_c2(c2[2]), .pin_c3(c3[2]), .pin_c4(c4[2]), .rom_addr(rom_addr[2]),
    .rom_cs(rom_cs[2]), .rom_data(rom_data[2]), .mi(mi[2]), .mi_vld(vld[2]), .mi_err(err[2]));
  assign rom_data[0] = mem[rom_addr[0]];
  assign rom_data[1] = mem[rom_addr[1]];
  assign rom_data[2] = mem[rom_addr[2]];
  function automatic logic [3:0] mask_of(input int u);
    return (u == 1) ? 4'h7 : 4'hF;
  endfunction
  function automatic int ph_of(input int u);
    return (u == 2) ? 3 : 1;
  endfunction
  function automatic logic [3:0] ph(input int u);
    return {c1[u], c2[u], c3[u], c4[u]};
  endfunction
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
    end
  endtask
  task automatic fetch(input int u, input logic [10:0] a, input int extra, input bit keep, output int k);
    int n;
    logic [3:0] m;
    exp_t e;
    m = mask_of(u);
    req[u] = 1'b1;
    addr[u] = a;
    #1;
    n = 0;
    while (!ack[u] && n < 40) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (!ack[u]) begin
      chk("ack_timeout", 0, 1);
      k = -1;
    end else begin
      k = cyc;
      e.u = u;
      e.mi = m[a[10:9]] ? mem[a] : 22'h0;
      e.err = ~m[a[10:9]];
      e.t = k + 3 * ph_of(u) + 1 + extra;
      sb.push_back(e);
    end
    @(negedge clk);
    if (!keep) req[u] = 1'b0;
  endtask
  always @(negedge clk) begin
    int idx;
    if (!rst_n) sb.delete();
    else for (int u = 0; u < 3; u++) if (vld[u]) begin
      idx = -1;
      foreach (sb[i]) if (idx < 0 && sb[i].u == u) idx = i;
      if (idx < 0) chk("vld_unexpected", 1, 0);
      else begin
        chk("mi", 32'(mi[u]), 32'(sb[idx].mi));
        chk("mi_err", 32'(err[u]), 32'(sb[idx].err));
        chk("latency", cyc, sb[idx].t);
        sb.delete(idx);
      end
    end
  end
  initial begin
    logic [3:0] eph [4] = '{4'b0100, 4'b0010, 4'b0001, 4'b1000};
    logic [3:0] ecs [4] = '{4'b0010, 4'b0010, 4'b0000, 4'b0000};
    logic [10:0] bb [3] = '{11'h000, 11'h001, 11'h7FF};
    logic [3:0] bcs [3] = '{4'b0001, 4'b0001, 4'b1000};
    int k, kp;
    for (int i = 0; i < 2048; i++) mem[i] = 22'(i * 40503 + 32'h1234);
    mem[11'h205] = 22'h2A5A5A;
    for (int u = 0; u < 3; u++) addr[u] = '0;
    repeat (3) @(negedge clk);
    for (int u = 0; u < 3; u++) begin
      chk("rst_ph", 32'(ph(u)), 0);
      chk("rst_cs", 32'(rom_cs[u]), 0);
      chk("rst_raddr", 32'(rom_addr[u]), 0);
      chk("rst_mi", 32'({mi[u], vld[u], err[u]}), 0);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    fetch(0, 11'h205, 0, 0, k);
    for (int i = 0; i < 4; i++) begin
      chk("s_ph", 32'(ph(0)), 32'(eph[i]));
      chk("s_cs", 32'(rom_cs[0]), 32'(ecs[i]));
      chk("s_vld", 32'(vld[0]), (i == 3) ? 1 : 0);
      @(negedge clk);
    end
    chk("s_idle", 32'(ph(0)), 0);
    chk("s_hold", 32'(mi[0]), 32'h2A5A5A);
    chk("s_raddr", 32'(rom_addr[0]), 32'h205);
    repeat (2) @(negedge clk);
    kp = -1;
    for (int i = 0; i < 3; i++) begin
      fetch(0, bb[i], 0, i < 2, k);
      chk("bb_cs", 32'(rom_cs[0]), 32'(bcs[i]));
      if (kp >= 0) chk("bb_ack_gap", k - kp, 4);
      kp = k;
    end
    repeat (6) @(negedge clk);
    fetch(1, 11'h600, 0, 0, k);
    for (int i = 0; i < 3; i++) begin
      chk("ub_cs", 32'(rom_cs[1]), 0);
      @(negedge clk);
    end
    chk("ub_vld_err", 32'({vld[1], err[1]}), 32'b11);
    repeat (3) @(negedge clk);
    fetch(2, 11'h123, 5, 0, k);
    stall[2] = 1'b1;
    @(negedge clk);
    stall[2] = 1'b0;
    chk("st_ph2", 32'(ph(2)), 32'b0100);
    repeat (7) @(negedge clk);
    chk("st_ph4", 32'(ph(2)), 32'b0001);
    stall[2] = 1'b1;
    repeat (5) @(negedge clk);
    stall[2] = 1'b0;
    chk("st_held", 32'(ph(2)), 32'b0001);
    @(negedge clk);
    chk("st_ph1", 32'(ph(2)), 32'b1000);
    repeat (4) @(negedge clk);
    fetch(0, 11'h0AA, 0, 0, k);
    @(negedge clk);
    chk("rm_ph3", 32'(ph(0)), 32'b0010);
    rst_n = 1'b0;
    #1;
    chk("rm_ph", 32'(ph(0)), 0);
    chk("rm_cs", 32'(rom_cs[0]), 0);
    chk("rm_mi", 32'(mi[0]), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    fetch(0, 11'h3C0, 0, 0, k);
    repeat (10) @(negedge clk);
    chk("pending", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
